// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// dmem_arbiter_if: bundles the core port, the DMA/debug port and the
// single-port data memory interface seen by dmem_arbiter.
// slave  : the arbiter's view (requests in, grants/responses/memory drive out)
// master : the surrounding system's view (requesters plus the RAM)
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // core (port C)
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // DMA / debug (port D)
    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // data memory
    logic              mem_WE;
    logic [DATA_W-1:0] mem_WD;
    logic [ADDR_W-1:0] mem_Address;
    logic [DATA_W-1:0] mem_RD;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_WE, mem_WD, mem_Address,
        input  mem_RD
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_WE, mem_WD, mem_Address,
        output mem_RD
    );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares the single-port data RAM between the core (C) and a
// DMA/debug port (D). C has fixed priority; D is protected from starvation
// after MAX_WAIT denied cycles and may hold the RAM with a lock, which is
// broken after MAX_LOCK locked grants made while C is waiting.
// Grants and the memory drive are combinational; responses are registered
// and appear in the cycle after the grant.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

    lock_state_t       state_r;
    lock_state_t       state_s;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        wait_cnt_s;
    logic [3:0]        lock_cnt_r;
    logic [3:0]        lock_cnt_s;

    logic              locked_s;
    logic              force_rel_s;
    logic              c_win_s;
    logic              d_win_s;

    logic              c_rvalid_r;
    logic              d_rvalid_r;
    logic [DATA_W-1:0] c_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    assign locked_s    = (state_r == ST_LOCKED);
    // The lock is broken once D has taken MAX_LOCK locked grants in a row
    // while C was asking for the RAM.
    assign force_rel_s = (lock_cnt_r == MAX_LOCK_C) && bus.c_req;

    // Pick at most one winner: held lock, then starvation, then core, then DMA.
    always_comb begin
        c_win_s = 1'b0;
        d_win_s = 1'b0;
        if (locked_s && bus.d_req && !force_rel_s) begin
            d_win_s = 1'b1;
        end else if ((wait_cnt_r == MAX_WAIT_C) && bus.d_req) begin
            d_win_s = 1'b1;
        end else if (bus.c_req) begin
            c_win_s = 1'b1;
        end else if (bus.d_req) begin
            d_win_s = 1'b1;
        end else begin
            c_win_s = 1'b0;
            d_win_s = 1'b0;
        end
    end

    // Route the winner onto the memory bus; everything is quiet in reset or idle.
    always_comb begin
        bus.c_gnt       = 1'b0;
        bus.d_gnt       = 1'b0;
        bus.mem_WE      = 1'b0;
        bus.mem_Address = {ADDR_W{1'b0}};
        bus.mem_WD      = {DATA_W{1'b0}};
        if (!reset) begin
            bus.c_gnt       = 1'b0;
            bus.d_gnt       = 1'b0;
            bus.mem_WE      = 1'b0;
            bus.mem_Address = {ADDR_W{1'b0}};
            bus.mem_WD      = {DATA_W{1'b0}};
        end else if (c_win_s) begin
            bus.c_gnt       = 1'b1;
            bus.mem_WE      = bus.c_we;
            bus.mem_Address = bus.c_addr;
            bus.mem_WD      = bus.c_wdata;
        end else if (d_win_s) begin
            bus.d_gnt       = 1'b1;
            bus.mem_WE      = bus.d_we;
            bus.mem_Address = bus.d_addr;
            bus.mem_WD      = bus.d_wdata;
        end else begin
            bus.c_gnt       = 1'b0;
            bus.d_gnt       = 1'b0;
        end
    end

    // Next values of the starvation counter and the locked-grant counter.
    always_comb begin
        wait_cnt_s = wait_cnt_r;
        lock_cnt_s = lock_cnt_r;

        // D denied while asking: count up to MAX_WAIT and stay there.
        if (bus.d_req && !d_win_s) begin
            if (wait_cnt_r == MAX_WAIT_C) begin
                wait_cnt_s = wait_cnt_r;
            end else begin
                wait_cnt_s = wait_cnt_r + 4'd1;
            end
        end else begin
            wait_cnt_s = 4'd0;
        end

        // Only locked grants taken while C is waiting count toward release.
        if (d_win_s && locked_s && bus.c_req) begin
            if (lock_cnt_r == MAX_LOCK_C) begin
                lock_cnt_s = lock_cnt_r;
            end else begin
                lock_cnt_s = lock_cnt_r + 4'd1;
            end
        end else begin
            lock_cnt_s = 4'd0;
        end
    end

    // Lock state machine: enter on a D grant with d_lock, leave otherwise.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_OPEN: begin
                if (d_win_s && bus.d_lock) begin
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_OPEN;
                end
            end
            ST_LOCKED: begin
                if (force_rel_s) begin
                    state_s = ST_OPEN;
                end else if (d_win_s && bus.d_lock) begin
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_OPEN;
                end
            end
            default: begin
                state_s = ST_OPEN;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_OPEN;
            wait_cnt_r <= 4'd0;
            lock_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            lock_cnt_r <= lock_cnt_s;
        end
    end

    // Responses: one-cycle rvalid to the winner; rdata updates only on reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            c_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            c_rvalid_r <= c_win_s;
            d_rvalid_r <= d_win_s;
            if (c_win_s && !bus.c_we) begin
                c_rdata_r <= bus.mem_RD;
            end else begin
                c_rdata_r <= c_rdata_r;
            end
            if (d_win_s && !bus.d_we) begin
                d_rdata_r <= bus.mem_RD;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign bus.c_rvalid = c_rvalid_r;
    assign bus.c_rdata  = c_rdata_r;
    assign bus.d_rvalid = d_rvalid_r;
    assign bus.d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: directed table and hand-written sequences plus random
// traffic, checked against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int MAX_LOCK = 8;
    localparam int LOCK_END = 2 + MAX_LOCK;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(
        .DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the arbiter: combinational read, write at the rising edge
    logic [31:0] ram [0:255];
    assign bus.mem_RD = ram[bus.mem_Address[9:2]];
    always @(posedge clk) begin
        if (bus.mem_WE) ram[bus.mem_Address[9:2]] <= bus.mem_WD;
    end

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h0001_0203) ^ 32'hA500_0000;
    endfunction

    // ---------------- reference model ----------------
    int          m_wait;      // consecutive cycles D asked and was refused
    bit          m_locked;    // D holds the RAM
    int          m_lrun;      // locked D grants in a row while C waited
    logic        m_crv, m_drv;
    logic [31:0] m_crd, m_drd;
    logic [31:0] m_mem [0:255];

    // samples taken in the most recent step, before its clock edge
    logic        s_c_gnt, s_d_gnt, s_mem_we, s_c_rvalid, s_d_rvalid;
    logic [31:0] s_mem_addr, s_c_rdata;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic mreset();
        m_wait = 0; m_locked = 1'b0; m_lrun = 0;
        m_crv = 1'b0; m_drv = 1'b0; m_crd = 32'd0; m_drd = 32'd0;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic dl,
                        input logic [31:0] da, input logic [31:0] dd);
        int          who;   // 0 nobody, 1 core, 2 DMA
        bit          rel;
        logic        e_we;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.d_req = dr; bus.d_we = dw; bus.d_lock = dl; bus.d_addr = da; bus.d_wdata = dd;
        #1;
        rel = (m_lrun == MAX_LOCK) && (cr == 1'b1);
        if (m_locked && dr && !rel)      who = 2;
        else if (dr && m_wait >= MAX_WAIT) who = 2;
        else if (cr)                     who = 1;
        else if (dr)                     who = 2;
        else                             who = 0;
        e_we = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
        if (who == 1) begin e_we = cw; e_addr = ca; e_wd = cd; end
        if (who == 2) begin e_we = dw; e_addr = da; e_wd = dd; end

        chk("c_gnt",    32'(bus.c_gnt),    32'(who == 1));
        chk("d_gnt",    32'(bus.d_gnt),    32'(who == 2));
        chk("mem_WE",   32'(bus.mem_WE),   32'(e_we));
        chk("mem_Addr", bus.mem_Address,   e_addr);
        chk("mem_WD",   bus.mem_WD,        e_wd);
        chk("c_rvalid", 32'(bus.c_rvalid), 32'(m_crv));
        chk("c_rdata",  bus.c_rdata,       m_crd);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_drv));
        chk("d_rdata",  bus.d_rdata,       m_drd);

        s_c_gnt = bus.c_gnt; s_d_gnt = bus.d_gnt; s_mem_we = bus.mem_WE;
        s_mem_addr = bus.mem_Address; s_c_rvalid = bus.c_rvalid;
        s_d_rvalid = bus.d_rvalid; s_c_rdata = bus.c_rdata;

        // state after this cycle's rising edge
        m_crv = (who == 1);
        m_drv = (who == 2);
        if (who == 1 && !cw) m_crd = m_mem[ca[9:2]];
        if (who == 2 && !dw) m_drd = m_mem[da[9:2]];
        if (who != 0 && e_we) m_mem[e_addr[9:2]] = e_wd;
        if (dr && who != 2) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        else                m_wait = 0;
        if (who == 2 && m_locked && cr) m_lrun = m_lrun + 1;
        else                            m_lrun = 0;
        m_locked = (who == 2) && (dl == 1'b1);
        @(posedge clk);
    endtask

    typedef struct {
        logic c_req;
        logic d_req;
        logic d_we;
        logic exp_c_gnt;
        logic exp_d_gnt;
        logic exp_d_rvalid;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int burst;
        logic cr, dr, dl;

        n_checks = 0;
        n_errors = 0;
        burst    = 0;

        // contention/starvation, then a one-cycle D pulse, then idle
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 256; i++) begin
            ram[i]   <= init_word(i);
            m_mem[i]  = init_word(i);
        end
        mreset();

        // ---- reset held with both ports requesting ----
        reset = 1'b1;
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h20; bus.c_wdata = 32'h1111_1111;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 32'h24;
        bus.d_wdata = 32'h2222_2222;
        #1 reset = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        chk("rst_c_gnt",    32'(bus.c_gnt),    32'd0);
        chk("rst_d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("rst_mem_WE",   32'(bus.mem_WE),   32'd0);
        chk("rst_mem_addr", bus.mem_Address,   32'd0);
        chk("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_c_rdata",  bus.c_rdata,       32'd0);
        chk("rst_d_rdata",  bus.d_rdata,       32'd0);
        bus.c_req = 1'b0; bus.d_req = 1'b0; bus.d_lock = 1'b0;
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst_release_c_gnt", 32'(s_c_gnt), 32'd1);

        // ---- core write then read ----
        step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("wr_mem_WE",   32'(s_mem_we), 32'd1);
        chk("wr_mem_addr", s_mem_addr,    32'h10);
        step(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("wr_c_rvalid1", 32'(s_c_rvalid), 32'd1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rd_c_rvalid2", 32'(s_c_rvalid), 32'd1);
        chk("rd_c_rdata",   s_c_rdata,       32'hDEAD_BEEF);

        // ---- table: starvation, drop pulse, idle ----
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].c_req, 1'b0, 32'h100, 32'd0,
                 tbl[i].d_req, tbl[i].d_we, 1'b0, 32'h40, 32'hBAD0_BAD0);
            chk($sformatf("tbl%0d_c_gnt", i),    32'(s_c_gnt),    32'(tbl[i].exp_c_gnt));
            chk($sformatf("tbl%0d_d_gnt", i),    32'(s_d_gnt),    32'(tbl[i].exp_d_gnt));
            chk($sformatf("tbl%0d_d_rvalid", i), 32'(s_d_rvalid), 32'(tbl[i].exp_d_rvalid));
        end
        chk("drop_mem_unchanged", ram[16], init_word(16));

        // ---- locked burst, C joins at cycle 2 ----
        for (int k = 0; k < 12; k++) begin
            step(k >= 2, 1'b0, 32'h180, 32'd0, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(4 * k), 32'd0);
            chk($sformatf("lock%0d_c_gnt", k), 32'(s_c_gnt), 32'(k >= LOCK_END));
            chk($sformatf("lock%0d_d_gnt", k), 32'(s_d_gnt), 32'(k < LOCK_END));
        end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---- async reset during a locked D read ----
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h200, 32'd0);
        @(negedge clk);
        bus.c_req = 1'b0; bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_we = 1'b0;
        bus.d_addr = 32'h204;
        #1;
        chk("arst_pre_d_gnt",    32'(bus.d_gnt),    32'd1);
        chk("arst_pre_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("arst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("arst_mem_WE",   32'(bus.mem_WE),   32'd0);
        bus.d_req = 1'b0; bus.d_lock = 1'b0;
        mreset();
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h300, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("arst_after_c_gnt", 32'(s_c_gnt), 32'd1);

        // ---- random traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(4, 24);
            cr = ($urandom_range(0, 99) < 60);
            dr = (burst > 0) ? 1'b1 : ($urandom_range(0, 99) < 45);
            dl = (burst > 1) ? 1'b1 : ($urandom_range(0, 99) < 30);
            if (burst > 0) burst--;
            step(cr, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 dr, 1'($urandom_range(0, 1)), dl, $urandom & 32'hFFFF_FFFC, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
